// File: rtl/daq_rx_rate_sel_fsm_pkg.sv
// Shared definitions for the DAQ receive-side rate selector: state encodings,
// GTX RXRATE codes and default bring-up timing.
package daq_rx_rate_pkg;

  typedef enum logic [2:0] {
    S_REQ        = 3'd0,
    S_WAIT_RATE  = 3'd1,
    S_CDR_RST    = 3'd2,
    S_PCS_RST    = 3'd3,
    S_WAIT_ALIGN = 3'd4,
    S_UP         = 3'd5,
    S_FAIL       = 3'd6
  } rx_state_e;

  localparam logic [1:0] RXRATE_3_2  = 2'b11;
  localparam logic [1:0] RXRATE_1_25 = 2'b10;

  localparam int DEF_CDR_RST_CYCLES = 8;
  localparam int DEF_PCS_RST_CYCLES = 4;
  localparam int DEF_RATE_TIMEOUT   = 1023;
  localparam int DEF_ALIGN_TIMEOUT  = 4095;
  localparam int DEF_MAX_RETRY      = 3;

  // Only the two legal RXRATE codes can ever be produced.
  function automatic logic [1:0] rate_code(input logic fast);
    return fast ? RXRATE_3_2 : RXRATE_1_25;
  endfunction

endpackage

// File: rtl/daq_rx_rate_sel_fsm_if.sv
// Signals between the DAQ rate control / RX GTX wrapper and the rate selector.
// The master side is the selector itself; the slave side is its environment.
interface daq_rx_rate_sel_fsm_if;

  logic       daq_rate;
  logic       rxratedone;
  logic       rxbyteisaligned;
  logic [1:0] rxrate_sel;
  logic       rxcdrreset;
  logic       rxpcsrst;
  logic       rxbufreset;
  logic       rate_1_25;
  logic       rate_3_2;
  logic       link_up;
  logic       rx_fail;
  logic [1:0] retry_cnt;
  logic [2:0] rxrt_state;

  modport master (
    input  daq_rate, rxratedone, rxbyteisaligned,
    output rxrate_sel, rxcdrreset, rxpcsrst, rxbufreset,
           rate_1_25, rate_3_2, link_up, rx_fail, retry_cnt, rxrt_state
  );

  modport slave (
    output daq_rate, rxratedone, rxbyteisaligned,
    input  rxrate_sel, rxcdrreset, rxpcsrst, rxbufreset,
           rate_1_25, rate_3_2, link_up, rx_fail, retry_cnt, rxrt_state
  );

endinterface

// File: rtl/daq_rx_rate_sel_fsm.sv
// GTX receiver rate selector: retunes RXRATE on a DAQ_RATE change, then runs
// CDR reset, PCS/buffer reset and byte-alignment wait with bounded retries.
module daq_rx_rate_sel_fsm
  import daq_rx_rate_pkg::*;
#(
  parameter int CDR_RST_CYCLES = DEF_CDR_RST_CYCLES,
  parameter int PCS_RST_CYCLES = DEF_PCS_RST_CYCLES,
  parameter int RATE_TIMEOUT   = DEF_RATE_TIMEOUT,
  parameter int ALIGN_TIMEOUT  = DEF_ALIGN_TIMEOUT,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  daq_rx_rate_sel_fsm_if.master rx_if
);

  localparam logic [15:0] LP_RATE_TO   = 16'(RATE_TIMEOUT);
  localparam logic [15:0] LP_CDR_LAST  = 16'(CDR_RST_CYCLES - 1);
  localparam logic [15:0] LP_PCS_LAST  = 16'(PCS_RST_CYCLES - 1);
  localparam logic [15:0] LP_ALIGN_TO  = 16'(ALIGN_TIMEOUT);
  localparam logic [1:0]  LP_MAX_RETRY = 2'(MAX_RETRY);

  rx_state_e   r_state;
  logic        r_tgt;
  logic [15:0] r_cnt;
  logic [1:0]  r_retry;
  logic [1:0]  r_rxrate_sel;
  logic        r_cdr_rst;
  logic        r_pcs_rst;
  logic        r_buf_rst;
  logic        r_rate_1_25;
  logic        r_rate_3_2;
  logic        r_link_up;
  logic        r_rx_fail;

  rx_state_e   w_next;
  logic        w_tgt_next;
  logic [15:0] w_cnt_inc;
  logic [15:0] w_cnt_next;
  logic [1:0]  w_retry_next;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    w_next       = r_state;
    w_tgt_next   = r_tgt;
    w_retry_next = r_retry;
    w_cnt_inc    = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    case (r_state)
      S_REQ: begin
        w_tgt_next   = rx_if.daq_rate;
        w_retry_next = '0;
        w_next       = S_WAIT_RATE;
      end
      S_WAIT_RATE: begin
        if (rx_if.rxratedone)       w_next = S_CDR_RST;
        else if (r_cnt == LP_RATE_TO) w_next = S_FAIL;
      end
      S_CDR_RST: begin
        if (r_cnt == LP_CDR_LAST) w_next = S_PCS_RST;
      end
      S_PCS_RST: begin
        if (r_cnt == LP_PCS_LAST) w_next = S_WAIT_ALIGN;
      end
      S_WAIT_ALIGN: begin
        if (rx_if.rxbyteisaligned) begin
          w_next = S_UP;
        end else if (r_cnt == LP_ALIGN_TO) begin
          if (r_retry < LP_MAX_RETRY) begin
            w_retry_next = r_retry + 2'd1;
            w_next       = S_CDR_RST;
          end else begin
            w_next = S_FAIL;
          end
        end
      end
      S_UP: begin
        w_retry_next = '0;
        if (!rx_if.rxbyteisaligned) w_next = S_CDR_RST;
      end
      S_FAIL: w_next = S_FAIL;
      default: w_next = S_REQ;
    endcase

    // A new requested rate pre-empts whatever the bring-up was doing.
    if (r_state != S_REQ && rx_if.daq_rate != r_tgt) w_next = S_REQ;

    // Every state entry starts its dwell count from zero.
    w_cnt_next = (w_next != r_state) ? '0 : w_cnt_inc;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_REQ;
      r_tgt        <= 1'b0;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_rxrate_sel <= RXRATE_1_25;
      r_cdr_rst    <= 1'b1;
      r_pcs_rst    <= 1'b1;
      r_buf_rst    <= 1'b1;
      r_rate_1_25  <= 1'b0;
      r_rate_3_2   <= 1'b0;
      r_link_up    <= 1'b0;
      r_rx_fail    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_tgt        <= w_tgt_next;
      r_cnt        <= w_cnt_next;
      r_retry      <= w_retry_next;
      // Outputs are decoded from the state being entered, so they line up
      // with r_state rather than trailing it by a cycle.
      r_rxrate_sel <= (w_next == S_REQ) ? rate_code(rx_if.daq_rate) : rate_code(w_tgt_next);
      r_cdr_rst    <= (w_next == S_CDR_RST);
      r_pcs_rst    <= (w_next == S_PCS_RST);
      r_buf_rst    <= (w_next == S_PCS_RST);
      r_rate_1_25  <= (w_next == S_UP) && !w_tgt_next;
      r_rate_3_2   <= (w_next == S_UP) &&  w_tgt_next;
      r_link_up    <= (w_next == S_UP);
      r_rx_fail    <= (w_next == S_FAIL);
    end
  end

  assign rx_if.rxrate_sel = r_rxrate_sel;
  assign rx_if.rxcdrreset = r_cdr_rst;
  assign rx_if.rxpcsrst   = r_pcs_rst;
  assign rx_if.rxbufreset = r_buf_rst;
  assign rx_if.rate_1_25  = r_rate_1_25;
  assign rx_if.rate_3_2   = r_rate_3_2;
  assign rx_if.link_up    = r_link_up;
  assign rx_if.rx_fail    = r_rx_fail;
  assign rx_if.retry_cnt  = r_retry;
  assign rx_if.rxrt_state = r_state;

endmodule

// File: tb/tb_daq_rx_rate_sel_fsm.sv
// Directed bench for daq_rx_rate_sel_fsm: bring-up at both rates, rate and
// alignment timeouts, retries, loss of alignment and rate-change/reset priority.
module tb_daq_rx_rate_sel_fsm;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  daq_rx_rate_sel_fsm_if rx_if ();

  daq_rx_rate_sel_fsm dut (
    .i_clk (clk),
    .i_rst (rst),
    .rx_if (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_if.daq_rate        = 1'b0;
    rx_if.rxratedone      = 1'b0;
    rx_if.rxbyteisaligned = 1'b1;
    tick();
    tick();
    checks++;
    if (rx_if.rxrt_state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", rx_if.rxrt_state);
    end
    checks++;
    if ({rx_if.rxcdrreset, rx_if.rxpcsrst, rx_if.rxbufreset} !== 3'b111) begin
      errors++; $display("FAIL reset_resets: got %b expected 111",
                         {rx_if.rxcdrreset, rx_if.rxpcsrst, rx_if.rxbufreset});
    end
    checks++;
    if (rx_if.rxrate_sel !== 2'b10) begin
      errors++; $display("FAIL reset_rate_sel: got %b expected 10", rx_if.rxrate_sel);
    end
    checks++;
    if ({rx_if.rate_1_25, rx_if.rate_3_2, rx_if.link_up, rx_if.rx_fail, rx_if.retry_cnt} !== 6'b0) begin
      errors++; $display("FAIL reset_status: got %b expected 000000",
                         {rx_if.rate_1_25, rx_if.rate_3_2, rx_if.link_up, rx_if.rx_fail, rx_if.retry_cnt});
    end
    rst = 1'b0;
  endtask

  task automatic test_bringup_1g25();
    int bad;
    tick();
    checks++;
    if (rx_if.rxrt_state !== 3'd1 || rx_if.rxrate_sel !== 2'b10) begin
      errors++; $display("FAIL wait_rate_entry: got state %0d sel %b expected 1 10",
                         rx_if.rxrt_state, rx_if.rxrate_sel);
    end
    repeat (3) tick();
    checks++;
    if (rx_if.rxrt_state !== 3'd1) begin
      errors++; $display("FAIL wait_rate_hold: got %0d expected 1", rx_if.rxrt_state);
    end
    rx_if.rxratedone = 1'b1;
    tick();
    rx_if.rxratedone = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      if (rx_if.rxrt_state !== 3'd2 || rx_if.rxcdrreset !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL cdr_rst_8_cycles: got %0d bad samples expected 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rx_if.rxrt_state !== 3'd3 || rx_if.rxpcsrst !== 1'b1 ||
          rx_if.rxbufreset !== 1'b1 || rx_if.rxcdrreset !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL pcs_rst_4_cycles: got %0d bad samples expected 0", bad);
    end
    tick();
    checks++;
    if (rx_if.rxrt_state !== 3'd4) begin
      errors++; $display("FAIL wait_align_entry: got %0d expected 4", rx_if.rxrt_state);
    end
    tick();
    checks++;
    if ({rx_if.rxrt_state, rx_if.rate_1_25, rx_if.rate_3_2, rx_if.link_up, rx_if.rxrate_sel}
        !== {3'd5, 1'b1, 1'b0, 1'b1, 2'b10}) begin
      errors++; $display("FAIL up_1g25: got state %0d r125 %b r32 %b up %b sel %b expected 5 1 0 1 10",
                         rx_if.rxrt_state, rx_if.rate_1_25, rx_if.rate_3_2, rx_if.link_up, rx_if.rxrate_sel);
    end
  endtask

  task automatic test_rate_change_3g2();
    int n;
    rx_if.daq_rate = 1'b1;
    tick();
    checks++;
    if ({rx_if.rxrt_state, rx_if.rxrate_sel, rx_if.rate_1_25, rx_if.link_up} !== {3'd0, 2'b11, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rate_change_req: got state %0d sel %b r125 %b up %b expected 0 11 0 0",
                         rx_if.rxrt_state, rx_if.rxrate_sel, rx_if.rate_1_25, rx_if.link_up);
    end
    tick();
    rx_if.rxratedone = 1'b1;
    tick();
    rx_if.rxratedone = 1'b0;
    n = 0;
    while (rx_if.rxrt_state !== 3'd5 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 13) begin
      errors++; $display("FAIL bringup_3g2_len: got %0d cycles expected 13", n);
    end
    checks++;
    if ({rx_if.rate_3_2, rx_if.rate_1_25, rx_if.link_up, rx_if.rxrate_sel} !== {1'b1, 1'b0, 1'b1, 2'b11}) begin
      errors++; $display("FAIL up_3g2: got r32 %b r125 %b up %b sel %b expected 1 0 1 11",
                         rx_if.rate_3_2, rx_if.rate_1_25, rx_if.link_up, rx_if.rxrate_sel);
    end
  endtask

  task automatic test_rate_timeout();
    int n;
    rx_if.daq_rate = 1'b0;
    tick();
    tick();
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      if (rx_if.rxrt_state !== 3'd1) break;
      n++;
      tick();
    end
    checks++;
    if (n != 1024) begin
      errors++; $display("FAIL rate_timeout_len: got %0d cycles expected 1024", n);
    end
    checks++;
    if ({rx_if.rxrt_state, rx_if.rx_fail, rx_if.link_up, rx_if.rxrate_sel} !== {3'd6, 1'b1, 1'b0, 2'b10}) begin
      errors++; $display("FAIL rate_timeout_fail: got state %0d fail %b up %b sel %b expected 6 1 0 10",
                         rx_if.rxrt_state, rx_if.rx_fail, rx_if.link_up, rx_if.rxrate_sel);
    end
    rx_if.rxratedone = 1'b1;
    tick();
    rx_if.rxratedone = 1'b0;
    tick();
    checks++;
    if (rx_if.rxrt_state !== 3'd6 || rx_if.rx_fail !== 1'b1) begin
      errors++; $display("FAIL fail_ignores_done: got state %0d fail %b expected 6 1",
                         rx_if.rxrt_state, rx_if.rx_fail);
    end
    rx_if.daq_rate = 1'b1;
    tick();
    checks++;
    if ({rx_if.rxrt_state, rx_if.rx_fail, rx_if.rxrate_sel} !== {3'd0, 1'b0, 2'b11}) begin
      errors++; $display("FAIL fail_exit_on_rate: got state %0d fail %b sel %b expected 0 0 11",
                         rx_if.rxrt_state, rx_if.rx_fail, rx_if.rxrate_sel);
    end
  endtask

  task automatic test_align_retry();
    int       pulses;
    int       align_cycles;
    logic     prev_cdr;
    logic [1:0] retry_seen [4];
    rx_if.rxbyteisaligned = 1'b0;
    tick();
    rx_if.rxratedone = 1'b1;
    tick();
    rx_if.rxratedone = 1'b0;
    pulses       = 0;
    align_cycles = 0;
    prev_cdr     = 1'b0;
    for (int i = 0; i < 4; i++) retry_seen[i] = 2'b00;
    for (int i = 0; i < 20000; i++) begin
      if (rx_if.rxcdrreset === 1'b1 && !prev_cdr) begin
        if (pulses < 4) retry_seen[pulses] = rx_if.retry_cnt;
        pulses++;
      end
      prev_cdr = rx_if.rxcdrreset;
      if (rx_if.rxrt_state === 3'd4) align_cycles++;
      if (rx_if.rxrt_state === 3'd6) break;
      tick();
    end
    checks++;
    if (rx_if.rxrt_state !== 3'd6 || rx_if.rx_fail !== 1'b1) begin
      errors++; $display("FAIL retry_exhausted: got state %0d fail %b expected 6 1",
                         rx_if.rxrt_state, rx_if.rx_fail);
    end
    checks++;
    if (pulses != 4) begin
      errors++; $display("FAIL cdr_pulse_count: got %0d expected 4", pulses);
    end
    checks++;
    if (align_cycles != 16384) begin
      errors++; $display("FAIL align_wait_total: got %0d expected 16384", align_cycles);
    end
    checks++;
    if ({retry_seen[0], retry_seen[1], retry_seen[2], retry_seen[3]} !== 8'b00_01_10_11) begin
      errors++; $display("FAIL retry_sequence: got %0d %0d %0d %0d expected 0 1 2 3",
                         retry_seen[0], retry_seen[1], retry_seen[2], retry_seen[3]);
    end
    checks++;
    if (rx_if.retry_cnt !== 2'd3) begin
      errors++; $display("FAIL retry_at_fail: got %0d expected 3", rx_if.retry_cnt);
    end
  endtask

  task automatic test_align_loss();
    int n;
    int bad;
    rx_if.rxbyteisaligned = 1'b1;
    rx_if.daq_rate        = 1'b0;
    tick();
    tick();
    rx_if.rxratedone = 1'b1;
    tick();
    rx_if.rxratedone = 1'b0;
    n = 0;
    while (rx_if.rxrt_state !== 3'd5 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (rx_if.rxrt_state !== 3'd5 || rx_if.rate_1_25 !== 1'b1) begin
      errors++; $display("FAIL relink_1g25: got state %0d r125 %b expected 5 1",
                         rx_if.rxrt_state, rx_if.rate_1_25);
    end
    rx_if.rxbyteisaligned = 1'b0;
    tick();
    rx_if.rxbyteisaligned = 1'b1;
    checks++;
    if ({rx_if.rxrt_state, rx_if.link_up, rx_if.rate_1_25, rx_if.rxcdrreset} !== {3'd2, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL align_drop: got state %0d up %b r125 %b cdr %b expected 2 0 0 1",
                         rx_if.rxrt_state, rx_if.link_up, rx_if.rate_1_25, rx_if.rxcdrreset);
    end
    n = 0;
    while (rx_if.rxrt_state !== 3'd5 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 13 || rx_if.retry_cnt !== 2'd0 || rx_if.link_up !== 1'b1) begin
      errors++; $display("FAIL align_recover: got %0d cycles retry %0d up %b expected 13 0 1",
                         n, rx_if.retry_cnt, rx_if.link_up);
    end
    // Alignment arriving on the very cycle the wait expires must win.
    rx_if.rxbyteisaligned = 1'b0;
    tick();
    n = 0;
    while (rx_if.rxrt_state !== 3'd4 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 12) begin
      errors++; $display("FAIL reach_wait_align: got %0d cycles expected 12", n);
    end
    bad = 0;
    for (int i = 0; i < 4095; i++) begin
      tick();
      if (rx_if.rxrt_state !== 3'd4) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL align_wait_4096: got %0d early exits expected 0", bad);
    end
    rx_if.rxbyteisaligned = 1'b1;
    tick();
    checks++;
    if ({rx_if.rxrt_state, rx_if.retry_cnt, rx_if.link_up} !== {3'd5, 2'd0, 1'b1}) begin
      errors++; $display("FAIL align_beats_timeout: got state %0d retry %0d up %b expected 5 0 1",
                         rx_if.rxrt_state, rx_if.retry_cnt, rx_if.link_up);
    end
  endtask

  task automatic test_priority();
    int n;
    rx_if.daq_rate = 1'b1;
    tick();
    tick();
    rx_if.daq_rate   = 1'b0;
    rx_if.rxratedone = 1'b1;
    tick();
    rx_if.rxratedone = 1'b0;
    checks++;
    if (rx_if.rxrt_state !== 3'd0 || rx_if.rxrate_sel !== 2'b10) begin
      errors++; $display("FAIL rate_beats_done: got state %0d sel %b expected 0 10",
                         rx_if.rxrt_state, rx_if.rxrate_sel);
    end
    rx_if.daq_rate = 1'b1;
    tick();
    rx_if.rxratedone = 1'b1;
    tick();
    rx_if.rxratedone = 1'b0;
    n = 0;
    while (rx_if.rxrt_state !== 3'd3 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 8 || rx_if.rxrate_sel !== 2'b11) begin
      errors++; $display("FAIL reach_pcs_rst: got %0d cycles sel %b expected 8 11", n, rx_if.rxrate_sel);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({rx_if.rxrt_state, rx_if.rxrate_sel, rx_if.rxcdrreset, rx_if.rxpcsrst, rx_if.rxbufreset,
         rx_if.link_up, rx_if.rx_fail, rx_if.retry_cnt} !== {3'd0, 2'b10, 3'b111, 2'b00, 2'd0}) begin
      errors++; $display("FAIL rst_mid_pcs: got state %0d sel %b resets %b up %b fail %b retry %0d expected 0 10 111 0 0 0",
                         rx_if.rxrt_state, rx_if.rxrate_sel,
                         {rx_if.rxcdrreset, rx_if.rxpcsrst, rx_if.rxbufreset},
                         rx_if.link_up, rx_if.rx_fail, rx_if.retry_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (rx_if.rxrt_state !== 3'd1 || rx_if.rxrate_sel !== 2'b11 || rx_if.rxcdrreset !== 1'b0) begin
      errors++; $display("FAIL post_rst_req: got state %0d sel %b cdr %b expected 1 11 0",
                         rx_if.rxrt_state, rx_if.rxrate_sel, rx_if.rxcdrreset);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bringup_1g25();
    test_rate_change_3g2();
    test_rate_timeout();
    test_align_retry();
    test_align_loss();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
